// File: rtl/dmem_access_unit.sv
// Load/store unit between the core data port and a word-wide synchronous RAM (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW).
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned LH/LHU/SH/LW/SW with rsp_err instead of lane-selecting.
module dmem_access_unit #(
  parameter  int ADDR_W    = 32,
  parameter  int RAM_WORDS = 1024,
  parameter  int RD_LAT    = 1,
  localparam int AW        = $clog2(RAM_WORDS)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_q
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t     state, state_nx;
  req_t       rq;
  logic       err_q;
  logic [1:0] cnt;
  logic       accept, bad, unsup, misalign;

  if (ADDR_W > AW + 2) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^req_addr[ADDR_W-1:AW+2];
  end

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'h0, b};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Sub-word stores overwrite only their lane of the word just read back.
  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] w, input logic [31:0] d);
    logic [31:0] mask, data;
    if (f3[1:0] == 2'b00) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      data = {24'h0, d[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      data = {16'h0, d[15:0]} << {off[1], 4'b0000};
    end
    merge = (w & ~mask) | data;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    unsup = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                   : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    bad = unsup | misalign;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      rq       <= '0;
      err_q    <= 1'b0;
      cnt      <= '0;
      ram_addr <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == RD_WAIT) ? cnt + 2'd1 : 2'd0;
      if (accept) begin
        rq       <= '{we: req_we, f3: req_funct3, off: req_addr[1:0], wdata: req_wdata};
        err_q    <= bad;
        ram_addr <= req_addr[AW+1:2];
      end
    end
  end

  // RAM strobes and the response are decoded from state so reset removes them immediately.
  always_comb begin
    state_nx  = state;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    ram_wdata = 32'h0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)                               state_nx = RESP;
          else if (req_we && req_funct3 == 3'b010) state_nx = WRITE;
          else                                   state_nx = RD_WAIT;
        end
      end
      RD_WAIT: begin
        ram_rden = (cnt == 2'd0);
        if (cnt == LAT_M1) state_nx = rq.we ? WRITE : RESP;
      end
      WRITE: begin
        ram_wren  = 1'b1;
        ram_wdata = (rq.f3 == 3'b010) ? rq.wdata : merge(rq.f3, rq.off, ram_q, rq.wdata);
        state_nx  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || rq.we) ? 32'h0 : load_ext(rq.f3, rq.off, ram_q);
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, corner sequences, random ops vs a byte-array model.
module tb_dmem_access_unit;

  localparam int ADDR_W    = 32;
  localparam int RAM_WORDS = 64;
  localparam int RD_LAT    = 1;
  localparam int AW        = $clog2(RAM_WORDS);
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [AW-1:0]     ram_addr;
  logic              ram_rden, ram_wren;
  logic [31:0]       ram_wdata, ram_q;

  dmem_access_unit #(.ADDR_W(ADDR_W), .RAM_WORDS(RAM_WORDS), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #5 CLK = ~CLK;

  logic [31:0] tb_mem [RAM_WORDS];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge CLK) begin
    if (ram_wren) tb_mem[ram_addr] <= ram_wdata;
    if (ram_rden) rd_pipe[0] <= tb_mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_q = rd_pipe[RD_LAT-1];

  // Reference memory as plain bytes, addressed modulo its size.
  logic [7:0] ref_b [RAM_WORDS*4];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err, output logic [31:0] ww);
    int unsigned a, base, nb, w;
    logic [31:0] v;
    bit unsup, mis;
    a     = addr % 32'(RAM_WORDS*4);
    unsup = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    mis   = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    err   = unsup || (CHECK && mis);
    rd    = 32'h0;
    ww    = 32'h0;
    if (err) return;
    nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    base = a - (a % nb);
    if (!we) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_b[base+i]) << (8*i));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd = v;
    end else begin
      for (int i = 0; i < nb; i++) ref_b[base+i] = wd[8*i +: 8];
      w  = a - (a % 4);
      ww = {ref_b[w+3], ref_b[w+2], ref_b[w+1], ref_b[w]};
    end
  endfunction

  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input logic [31:0] exp_ww);
    int n_rd, n_wr, k_rd, k_wr, k_rsp, e_nrd, e_nwr, e_kwr, e_krsp;
    logic [31:0] got_rd, got_wd;
    logic [AW-1:0] got_ra, got_wa;
    logic got_err, both, busy_rdy;
    logic [AW-1:0] e_ra;
    n_rd = 0; n_wr = 0; k_rd = 0; k_wr = 0; k_rsp = 0;
    both = 0; busy_rdy = 0; got_rd = 'x; got_err = 'x; got_wd = 'x; got_ra = 'x; got_wa = 'x;
    @(negedge CLK);
    chk({tag, ":ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge CLK); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    for (int k = 1; k <= 8 && k_rsp == 0; k++) begin
      @(negedge CLK);
      if (ram_rden) begin n_rd++; k_rd = k; got_ra = ram_addr; end
      if (ram_wren) begin n_wr++; k_wr = k; got_wd = ram_wdata; got_wa = ram_addr; end
      if (ram_rden && ram_wren) both = 1;
      if (req_ready) busy_rdy = 1;
      if (rsp_valid) begin k_rsp = k; got_rd = rsp_rdata; got_err = rsp_err; end
    end
    e_nrd  = (!exp_err && !(we && f3 == 3'd2)) ? 1 : 0;
    e_nwr  = (!exp_err && we) ? 1 : 0;
    e_kwr  = e_nwr ? ((f3 == 3'd2) ? 1 : 1 + RD_LAT) : 0;
    e_krsp = exp_err ? 1 : (!we ? 1 + RD_LAT : (f3 == 3'd2 ? 2 : 2 + RD_LAT));
    e_ra   = addr[AW+1:2];
    chk({tag, ":rsp_cycle"}, 32'(k_rsp), 32'(e_krsp));
    chk({tag, ":rdata"}, got_rd, exp_rd);
    chk({tag, ":err"}, 32'(got_err), 32'(exp_err));
    chk({tag, ":rden_count"}, 32'(n_rd), 32'(e_nrd));
    chk({tag, ":wren_count"}, 32'(n_wr), 32'(e_nwr));
    chk({tag, ":wren_cycle"}, 32'(k_wr), 32'(e_kwr));
    chk({tag, ":strobe_overlap"}, 32'(both), 32'd0);
    chk({tag, ":ready_busy"}, 32'(busy_rdy), 32'd0);
    if (n_rd > 0) begin
      chk({tag, ":rden_cycle"}, 32'(k_rd), 32'd1);
      chk({tag, ":rd_addr"}, 32'(got_ra), 32'(e_ra));
    end
    if (n_wr > 0) begin
      chk({tag, ":wr_addr"}, 32'(got_wa), 32'(e_ra));
      chk({tag, ":wdata"}, got_wd, exp_ww);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m_rd, m_ww, r;
    logic m_err;
    int acc_cyc[$];
    int n_rsp, rsp_bad;
    bit wr_seen, rsp_seen, ok;

    for (int w = 0; w < RAM_WORDS; w++) begin
      r = $urandom;
      tb_mem[w] = r;
      for (int i = 0; i < 4; i++) ref_b[4*w+i] = r[8*i +: 8];
    end
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 32'h0;
    RESET_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;

    repeat (2) @(negedge CLK);
    chk("reset:req_ready", 32'(req_ready), 32'd1);
    chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset:rsp_rdata", rsp_rdata, 32'd0);
    chk("reset:rsp_err", 32'(rsp_err), 32'd0);
    chk("reset:ram_rden", 32'(ram_rden), 32'd0);
    chk("reset:ram_wren", 32'(ram_wren), 32'd0);
    chk("reset:ram_addr", 32'(ram_addr), 32'd0);
    chk("reset:ram_wdata", ram_wdata, 32'd0);
    RESET_N = 1'b1;

    vecs.push_back(vec_t'{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd5, 32'h10, 32'h0, 32'h0000BEEF, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'd0, 32'h11, 32'h12345655, 32'h0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
    vecs.push_back(vec_t'{1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'd1, 32'h15, 32'h1234, 32'h0, 1'b1});
`else
    vecs.push_back(vec_t'{1'b0, 3'd2, 32'h12, 32'h0, 32'hDEAD55EF, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd1, 32'h13, 32'h0, 32'hFFFFDEAD, 1'b0});
`endif
    vecs.push_back(vec_t'{1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd6, 32'h10, 32'h0, 32'h0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 3'd7, 32'h10, 32'h0, 32'h0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'd4, 32'h10, 32'h11111111, 32'h0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'd1, 32'h16, 32'hAAAA8001, 32'h0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd1, 32'h16, 32'h0, 32'hFFFF8001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd5, 32'h16, 32'h0, 32'h00008001, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0});

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_ww);
      run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].err, m_ww);
    end

    // req_valid held high: accepts must be spaced by the full load turnaround.
    model(1'b0, 3'd2, 32'h10, 32'h0, m_rd, m_err, m_ww);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    n_rsp = 0; rsp_bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge CLK);
      if (req_ready) acc_cyc.push_back(c);
      if (rsp_valid) begin
        n_rsp++;
        if (rsp_rdata !== m_rd || rsp_err !== 1'b0) rsp_bad++;
      end
    end
    @(negedge CLK);
    req_valid = 1'b0;
    chk("b2b:accepts", 32'(acc_cyc.size()), 32'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("b2b:spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(2 + RD_LAT));
    chk("b2b:responses", 32'(n_rsp), 32'd4);
    chk("b2b:rsp_data_bad", 32'(rsp_bad), 32'd0);
    ok = 0;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge CLK);
      ok = req_ready;
    end
    chk("b2b:drain_ready", 32'(ok), 32'd1);

    // Reset during the read of an SH must abandon it without touching RAM.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h20; req_wdata = 32'h0000CAFE;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    chk("rst_mid:rden_before", 32'(ram_rden), 32'd1);
    #1 RESET_N = 1'b0;
    wr_seen = 0; rsp_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (ram_wren) wr_seen = 1;
      if (rsp_valid) rsp_seen = 1;
    end
    RESET_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (ram_wren) wr_seen = 1;
      if (rsp_valid) rsp_seen = 1;
    end
    chk("rst_mid:wren", 32'(wr_seen), 32'd0);
    chk("rst_mid:rsp_valid", 32'(rsp_seen), 32'd0);
    chk("rst_mid:ready", 32'(req_ready), 32'd1);
    model(1'b0, 3'd2, 32'h20, 32'h0, m_rd, m_err, m_ww);
    run_op("rst_mid:lw", 1'b0, 3'd2, 32'h20, 32'h0, m_rd, m_err, m_ww);

    for (int i = 0; i < 250; i++) begin
      logic we_r;
      logic [2:0] f3_r;
      logic [31:0] a_r, d_r;
      we_r = 1'($urandom);
      f3_r = 3'($urandom_range(0, 7));
      a_r  = $urandom;
      d_r  = $urandom;
      model(we_r, f3_r, a_r, d_r, m_rd, m_err, m_ww);
      run_op($sformatf("rnd%0d", i), we_r, f3_r, a_r, d_r, m_rd, m_err, m_ww);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
